aes_inv_round_ladder: RTL and testbench

- Iterative AES-256 inverse cipher: decrypts one 128-bit block per transaction using the 15 expanded round keys, applied in reverse order.
- Uses a single shared inverse-round datapath, a round counter and a small FSM, with valid/ready handshakes on both sides.
- Sits on the receive side of the AES datapath, opposite the unrolled encryption ladder, and uses the same round-key vector layout.

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_inv_round_block.sv | 45 ++++
 rtl/aes_inv_round_ladder.sv | 121 ++++++++++++
 tb/tb_aes_inv_round_ladder.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | aes_pkg                                                                     |
// | Shared AES constants, FSM encodings and GF(2^8) byte helpers.               |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package aes_pkg;

  localparam int NB_BYTE  = 8;
  localparam int N_BYTES  = 16;
  localparam int N_ROUNDS = 14;
  localparam int N_COLS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  function automatic logic [NB_BYTE-1:0] gf_xtime(input logic [NB_BYTE-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [NB_BYTE-1:0] gf_mul(input logic [NB_BYTE-1:0] a,
                                                input logic [NB_BYTE-1:0] b);
    logic [NB_BYTE-1:0] acc;
    logic [NB_BYTE-1:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < NB_BYTE; i++) begin
      if (b[i]) acc = acc ^ x;
      x = gf_xtime(x);
    end
    return acc;
  endfunction

  // Inverse affine transform followed by the field inverse computed as a^254.
  function automatic logic [NB_BYTE-1:0] inv_sbox(input logic [NB_BYTE-1:0] a);
    logic [NB_BYTE-1:0] b;
    logic [NB_BYTE-1:0] sq;
    logic [NB_BYTE-1:0] inv;
    b = {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ 8'h05;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < NB_BYTE; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round_block.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | aes_inv_round_block                                                         |
// | Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,    |
// | then InvMixColumns unless i_last is set.                                    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module aes_inv_round_block
  import aes_pkg::*;
(
  input  logic [NB_BYTE*N_BYTES-1:0] i_state,
  input  logic [NB_BYTE*N_BYTES-1:0] i_round_key,
  input  logic                       i_last,
  output logic [NB_BYTE*N_BYTES-1:0] o_state
);

  logic [NB_BYTE-1:0] w_byte [N_BYTES];
  logic [NB_BYTE-1:0] w_ark  [N_BYTES];
  logic [NB_BYTE-1:0] w_mix  [N_BYTES];

  // Byte k is row k%4, column k/4; InvShiftRows pulls row r from column c-r.
  for (genvar gk = 0; gk < N_BYTES; gk++) begin : g_byte
    localparam int c_row = gk % N_COLS;
    localparam int c_col = gk / N_COLS;
    localparam int c_src = c_row + N_COLS * ((c_col - c_row + N_COLS) % N_COLS);

    assign w_byte[gk] = i_state[(N_BYTES-1-gk)*NB_BYTE +: NB_BYTE];
    assign w_ark[gk]  = inv_sbox(w_byte[c_src])
                      ^ i_round_key[(N_BYTES-1-gk)*NB_BYTE +: NB_BYTE];
    assign o_state[(N_BYTES-1-gk)*NB_BYTE +: NB_BYTE] = i_last ? w_ark[gk] : w_mix[gk];
  end

  for (genvar gc = 0; gc < N_COLS; gc++) begin : g_col
    assign w_mix[4*gc+0] = gf_mul(w_ark[4*gc+0], 8'h0e) ^ gf_mul(w_ark[4*gc+1], 8'h0b)
                         ^ gf_mul(w_ark[4*gc+2], 8'h0d) ^ gf_mul(w_ark[4*gc+3], 8'h09);
    assign w_mix[4*gc+1] = gf_mul(w_ark[4*gc+0], 8'h09) ^ gf_mul(w_ark[4*gc+1], 8'h0e)
                         ^ gf_mul(w_ark[4*gc+2], 8'h0b) ^ gf_mul(w_ark[4*gc+3], 8'h0d);
    assign w_mix[4*gc+2] = gf_mul(w_ark[4*gc+0], 8'h0d) ^ gf_mul(w_ark[4*gc+1], 8'h09)
                         ^ gf_mul(w_ark[4*gc+2], 8'h0e) ^ gf_mul(w_ark[4*gc+3], 8'h0b);
    assign w_mix[4*gc+3] = gf_mul(w_ark[4*gc+0], 8'h0b) ^ gf_mul(w_ark[4*gc+1], 8'h0d)
                         ^ gf_mul(w_ark[4*gc+2], 8'h09) ^ gf_mul(w_ark[4*gc+3], 8'h0e);
  end

endmodule
`default_nettype wire

// File: rtl/aes_inv_round_ladder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | aes_inv_round_ladder                                                        |
// | Iterative AES-256 inverse cipher, one shared inverse round, valid/ready.    |
// | Optional key bank: define AES_INV_ROUND_LADDER_KEY_LATCH_EN.                |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module aes_inv_round_ladder
  import aes_pkg::fsm_state_t, aes_pkg::ST_IDLE, aes_pkg::ST_RUN, aes_pkg::ST_DONE;
#(
  parameter int NB_BYTE  = 8,
  parameter int N_BYTES  = 16,
  parameter int N_ROUNDS = 14
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [NB_BYTE*N_BYTES-1:0]             i_state,
  input  logic [NB_BYTE*N_BYTES*(N_ROUNDS+1)-1:0] i_round_key_vector,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [NB_BYTE*N_BYTES-1:0]             o_state
);

  localparam int NB_STATE = NB_BYTE * N_BYTES;
  localparam int N_KEYS   = N_ROUNDS + 1;
  localparam int NB_ROUND = 4;
  localparam bit BAD_CONF = (NB_BYTE  != aes_pkg::NB_BYTE)
                         || (N_BYTES  != aes_pkg::N_BYTES)
                         || (N_ROUNDS != aes_pkg::N_ROUNDS);
  localparam logic [NB_ROUND-1:0] c_first_round = NB_ROUND'(N_ROUNDS - 1);

  if (BAD_CONF) begin : g_bad_conf
    $error("aes_inv_round_ladder: only NB_BYTE=8, N_BYTES=16, N_ROUNDS=14 are supported");
  end

  fsm_state_t                 r_fsm;
  logic [NB_ROUND-1:0]        r_round;
  logic [NB_STATE-1:0]        r_state;
  logic                       r_valid;
  logic                       w_accept;
  logic [NB_STATE-1:0]        w_round_key;
  logic [NB_STATE-1:0]        w_round_out;
  logic [NB_STATE-1:0]        w_key_last;
  logic [NB_STATE*N_KEYS-1:0] w_key_src;
  logic [NB_STATE-1:0]        w_key_sel [16];

  assign o_ready  = (r_fsm == ST_IDLE) || ((r_fsm == ST_DONE) && i_ready);
  assign w_accept = i_valid && o_ready;
  assign o_valid  = r_valid;
  assign o_state  = r_state;

  // The whitening step at accept always uses the live port value.
  assign w_key_last = i_round_key_vector[N_ROUNDS*NB_STATE +: NB_STATE];

`ifdef AES_INV_ROUND_LADDER_KEY_LATCH_EN
  logic [NB_STATE*N_KEYS-1:0] r_key_bank;

  always_ff @(posedge i_clock) begin
    if (w_accept) r_key_bank <= i_round_key_vector;
  end

  assign w_key_src = r_key_bank;
`else
  assign w_key_src = i_round_key_vector;
`endif

  for (genvar gi = 0; gi < 16; gi++) begin : g_key_mux
    if (gi < N_KEYS) begin : g_key
      assign w_key_sel[gi] = w_key_src[gi*NB_STATE +: NB_STATE];
    end else begin : g_pad
      assign w_key_sel[gi] = '0;
    end
  end

  assign w_round_key = w_key_sel[r_round];

  aes_inv_round_block u_round (
    .i_state     (r_state),
    .i_round_key (w_round_key),
    .i_last      (r_round == '0),
    .o_state     (w_round_out)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fsm   <= ST_IDLE;
      r_round <= '0;
      r_state <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_state <= i_state ^ w_key_last;
      r_round <= c_first_round;
      r_fsm   <= ST_RUN;
      r_valid <= 1'b0;
    end else begin
      case (r_fsm)
        ST_RUN: begin
          r_state <= w_round_out;
          if (r_round == '0) begin
            r_fsm   <= ST_DONE;
            r_valid <= 1'b1;
          end else begin
            r_round <= r_round - 1'b1;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            r_fsm   <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        ST_IDLE: ;
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_round_ladder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_aes_inv_round_ladder                                                     |
// | Scoreboard bench: blocks are built by a forward AES-256 model and the DUT   |
// | must return the original plaintext.                                         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_aes_inv_round_ladder;

  logic           i_clock = 1'b0;
  logic           i_reset;
  logic           i_valid;
  logic           o_ready;
  logic [127:0]   i_state;
  logic [1919:0]  i_round_key_vector;
  logic           o_valid;
  logic           i_ready;
  logic [127:0]   o_state;

  aes_inv_round_ladder dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_valid            (i_valid),
    .o_ready            (o_ready),
    .i_state            (i_state),
    .i_round_key_vector (i_round_key_vector),
    .o_valid            (o_valid),
    .i_ready            (i_ready),
    .o_state            (o_state)
  );

  always #5 i_clock = ~i_clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge i_clock) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    bit           differ;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           outs[$];
  exp_t         mon_e;
  bit           prev_v = 1'b0;
  logic [127:0] cur_pt;
  bit           cur_differ;
  logic [7:0]   sbox [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tfail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // Forward S-box from a brute-force field inverse plus the affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand_key(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] v;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) v[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return v;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] kv);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    blk = pt ^ kv[127:0];
    for (int r = 1; r <= 14; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox[blk[127-8*k -: 8]];
      for (int k = 0; k < 16; k++) t[k] = s[(k % 4) + 4 * (((k / 4) + (k % 4)) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (r < 14) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = s[k];
      blk = blk ^ kv[r*128 +: 128];
    end
    return blk;
  endfunction

  // Accept observer: an accept at the next rising edge enqueues its expectation.
  always @(negedge i_clock) begin
    if (!i_reset && i_valid && o_ready)
      sb.push_back('{cur_pt, cur_differ, cyc + 1});
  end

  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got o_valid=1 with o_state %h, expected no output", o_state);
        end else begin
          chk_int("latency", cyc - sb[0].acc, 14);
        end
      end
      if (o_valid && i_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (mon_e.differ) begin
          checks++;
          if (o_state === mon_e.pt) begin
            failures++;
            $display("FAIL key_change_live: got %h expected any value but %h", o_state, mon_e.pt);
          end
        end else begin
          chk("plaintext", o_state, mon_e.pt);
        end
        outs.push_back(cyc);
      end
    end
    prev_v = o_valid;
  end

  task automatic send(input logic [127:0] ct, input logic [127:0] pt,
                      input logic [1919:0] keys, input bit differ);
    int n;
    if (keys !== i_round_key_vector) begin
      n = 0;
      while (n < 300) begin
        @(negedge i_clock);
        if (o_valid || o_ready) break;
        n++;
      end
      @(posedge i_clock);
      #1;
      i_round_key_vector = keys;
    end
    cur_pt     = pt;
    cur_differ = differ;
    i_state    = ct;
    i_valid    = 1'b1;
    n = 0;
    do begin
      @(negedge i_clock);
      n++;
    end while (!o_ready && n < 300);
    if (!o_ready) tfail("accept_timeout");
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge i_clock);
      n++;
    end
    if (sb.size() != 0) begin
      tfail("drain_timeout");
      sb.delete();
    end
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1919:0] kv;
    logic [1919:0] fips_kv;
    logic [127:0]  pt;
    logic [127:0]  pt2;
    logic [127:0]  ct;
    bit            rnd_done;
    int            n;

    build_sbox();
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_state = '0; i_round_key_vector = '0; cur_pt = '0; cur_differ = 1'b0;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    chk_int("reset_o_valid", int'(o_valid), 0);
    chk_int("reset_o_ready", int'(o_ready), 1);
    chk("reset_o_state", o_state, 128'h0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;

    // Known-answer block.
    fips_kv = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    send(128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, fips_kv, 1'b0);
    drain();

    // Backpressure on the same block.
    i_ready = 1'b0;
    send(128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, fips_kv, 1'b0);
    n = 0;
    while (!o_valid && n < 100) begin
      @(negedge i_clock);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge i_clock);
      chk_int("bp_o_valid", int'(o_valid), 1);
      chk("bp_o_state", o_state, 128'h00112233445566778899aabbccddeeff);
      chk_int("bp_o_ready", int'(o_ready), 0);
    end
    @(posedge i_clock);
    #1;
    i_ready = 1'b1;
    drain();

    // Back-to-back with i_valid held and the same keys.
    kv  = expand_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    pt  = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    send(encrypt(pt, kv), pt, kv, 1'b0);
    send(encrypt(pt2, kv), pt2, kv, 1'b0);
    drain();
    if (outs.size() >= 2) chk_int("b2b_gap", outs[outs.size()-1] - outs[outs.size()-2], 15);
    else tfail("b2b_outputs");

    // Input pulse while busy must be ignored.
    kv = expand_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = encrypt(pt, kv);
    send(ct, pt, kv, 1'b0);
    repeat (3) @(posedge i_clock);
    #1;
    i_valid = 1'b1; i_state = ~ct; cur_pt = ~pt;
    @(negedge i_clock);
    chk_int("busy_o_ready", int'(o_ready), 0);
    @(posedge i_clock);
    #1;
    i_valid = 1'b0; i_state = ct; cur_pt = pt;
    drain();

    // Reset in the middle of a block.
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(encrypt(pt, kv), pt, kv, 1'b0);
    repeat (7) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    sb.delete();
    @(negedge i_clock);
    chk_int("midrst_o_valid", int'(o_valid), 0);
    chk_int("midrst_o_ready", int'(o_ready), 1);
    chk("midrst_o_state", o_state, 128'h0);
    repeat (20) @(negedge i_clock);
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(encrypt(pt, kv), pt, kv, 1'b0);
    drain();

    // Keys corrupted right after accept.
    kv = expand_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    pt = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_ROUND_LADDER_KEY_LATCH_EN
    send(encrypt(pt, kv), pt, kv, 1'b0);
`else
    send(encrypt(pt, kv), pt, kv, 1'b1);
`endif
    i_round_key_vector = ~kv;
    drain();

    // Randomized blocks with random downstream stalls.
    rnd_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          if (b == 0 || $urandom_range(0, 1) == 1)
            kv = expand_key({$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom});
          pt = {$urandom, $urandom, $urandom, $urandom};
          send(encrypt(pt, kv), pt, kv, 1'b0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge i_clock);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
